fc_output_collector: RTL and testbench

//  Receiving end of the fully-connected layer's result stream (data/addr/valid plus done).

---
 rtl/fc_output_collector_if.sv | 26 ++
 rtl/fc_output_collector.sv | 152 +++++++++++++++
 tb/tb_fc_output_collector.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_output_collector_if.sv
// Score stream from the FC layer and the error stream back to it.
// master = FC layer side, slave = collector side.
interface fc_output_collector_if #(
    parameter int OUTPUT_SIZE = 10,
    parameter int DATA_W      = 16,
    parameter int AW          = $clog2(OUTPUT_SIZE)
);
    logic [DATA_W-1:0] in_data;
    logic [AW-1:0]     in_addr;
    logic              in_valid;
    logic              in_done;
    logic [DATA_W-1:0] err_data;
    logic [AW-1:0]     err_addr;
    logic              err_valid;
    logic              err_ready;

    modport master (
        output in_data, in_addr, in_valid, in_done, err_ready,
        input  err_data, err_addr, err_valid
    );

    modport slave (
        input  in_data, in_addr, in_valid, in_done, err_ready,
        output err_data, err_addr, err_valid
    );
endinterface

// File: rtl/fc_output_collector.sv
// Buffers one score vector, argmaxes it, then streams saturated score-minus-target errors;
// first err_valid OUTPUT_SIZE+1 cycles after in_done, each error beat held until err_ready.
module fc_output_collector #(
    parameter int OUTPUT_SIZE = 10,
    parameter int DATA_W      = 16,
    parameter int FRAC_BITS   = 8,
    parameter int AW          = $clog2(OUTPUT_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [AW-1:0]        label,
    fc_output_collector_if.slave io,
    output logic [AW-1:0]        pred_class,
    output logic [DATA_W-1:0]    pred_score,
    output logic                 pred_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err
);
    localparam logic [AW:0]       N_CLS = (AW+1)'(OUTPUT_SIZE);
    localparam logic [AW-1:0]     LAST  = AW'(OUTPUT_SIZE - 1);
    localparam logic [DATA_W-1:0] ONE   = DATA_W'(1 << FRAC_BITS);

    typedef enum logic [2:0] {IDLE, COLLECT, SCAN, ERR_OUT, FIN} state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] sbuf [OUTPUT_SIZE];
    logic [OUTPUT_SIZE-1:0]   bitmap_q;
    logic [AW-1:0]            label_q;
    logic                     label_ok_q;
    logic [AW-1:0]            idx_q;
    logic [AW-1:0]            best_idx_q;
    logic signed [DATA_W-1:0] best_score_q;

    logic [OUTPUT_SIZE-1:0]   wr_hit;
    logic [OUTPUT_SIZE-1:0]   bitmap_wr;
    logic                     addr_ok;
    logic                     label_in_range;
    logic                     better;
    logic                     hs;
    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] tgt;
    logic signed [DATA_W:0]   diff;
    logic [DATA_W-1:0]        err_sat;

    assign addr_ok        = {1'b0, io.in_addr} < N_CLS;
    assign label_in_range = {1'b0, label} < N_CLS;
    assign cur            = sbuf[idx_q];
    // Strictly greater keeps the lowest index on ties.
    assign better         = (idx_q == '0) || (cur > best_score_q);
    assign tgt            = (label_ok_q && (idx_q == label_q)) ? ONE : '0;
    assign diff           = {cur[DATA_W-1], cur} - {tgt[DATA_W-1], tgt};

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (io.in_valid && (io.in_addr == AW'(i))) wr_hit[i] = 1'b1;
        end
        bitmap_wr = bitmap_q | wr_hit;
    end

    always_comb begin
        err_sat = diff[DATA_W-1:0];
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            err_sat = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign io.err_valid = (state_q == ERR_OUT);
    assign io.err_addr  = io.err_valid ? idx_q : '0;
    assign io.err_data  = io.err_valid ? err_sat : '0;
    assign hs           = io.err_valid && io.err_ready;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = COLLECT;
            COLLECT: if (io.in_done) state_d = SCAN;
            SCAN:    if (idx_q == LAST) state_d = ERR_OUT;
            ERR_OUT: if (hs && (idx_q == LAST)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) sbuf[i] <= '0;
            bitmap_q     <= '0;
            label_q      <= '0;
            label_ok_q   <= 1'b0;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            pred_class   <= '0;
            pred_score   <= '0;
            pred_valid   <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < OUTPUT_SIZE; i++) sbuf[i] <= '0;
                        bitmap_q   <= '0;
                        label_q    <= label;
                        label_ok_q <= label_in_range;
                        addr_err   <= !label_in_range;
                        pred_valid <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < OUTPUT_SIZE; i++) begin
                        if (wr_hit[i]) sbuf[i] <= io.in_data;
                    end
                    bitmap_q <= bitmap_wr;
                    if (io.in_valid && !addr_ok) addr_err <= 1'b1;
                    // Same-cycle write counts toward completeness; unwritten entries stay 0.
                    if (io.in_done && (bitmap_wr != {OUTPUT_SIZE{1'b1}})) addr_err <= 1'b1;
                    idx_q <= '0;
                end
                SCAN: begin
                    if (better) begin
                        best_idx_q   <= idx_q;
                        best_score_q <= cur;
                    end
                    if (idx_q == LAST) begin
                        pred_class <= better ? idx_q : best_idx_q;
                        pred_score <= better ? cur : best_score_q;
                        pred_valid <= 1'b1;
                        idx_q      <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ERR_OUT: begin
                    if (hs) idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_output_collector.sv
// Directed bench for fc_output_collector: argmax, saturated error stream, stalls, addr_err, reset abort.
module tb_fc_output_collector;
    localparam int N  = 10;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] label  = '0;
    logic [AW-1:0] pred_class;
    logic [DW-1:0] pred_score;
    logic          pred_valid, busy, done, addr_err;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sc [N];
    int lbl;

    fc_output_collector_if #(.OUTPUT_SIZE(N), .DATA_W(DW)) bus ();

    fc_output_collector #(.OUTPUT_SIZE(N), .DATA_W(DW), .FRAC_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .label(label), .io(bus),
        .pred_class(pred_class), .pred_score(pred_score), .pred_valid(pred_valid),
        .busy(busy), .done(done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_err(input logic [DW-1:0] s, input int i, input int l);
        int d;
        d = int'($signed(s)) - ((i == l) ? 256 : 0);
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return d[DW-1:0];
    endfunction

    task automatic start(input int l);
        @(negedge clk);
        enable = 1'b1;
        label  = AW'(l);
        lbl    = l;
        @(negedge clk);
        enable = 1'b0;
        label  = '0;
    endtask

    // Writes every entry in order; in_done rides on the last write.
    task automatic send_all();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_addr  = AW'(i);
            bus.in_data  = sc[i];
            bus.in_done  = (i == N - 1);
        end
    endtask

    task automatic wait_err(input string tag);
        int k;
        k = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.in_valid = 1'b0;
                bus.in_done  = 1'b0;
            end
            if (bus.err_valid) begin
                k = j;
                break;
            end
        end
        chk({tag, "_latency"}, k, 11);
    endtask

    task automatic drain(input string tag, input int stall_beat, input int stall_n, input int abort_beat);
        int  beats, stalled, cyc;
        bit  seen_done, aborted;
        beats = 0; stalled = 0; cyc = 0; seen_done = 0; aborted = 0;
        while (cyc < 200) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (bus.err_valid) begin
                if (beats == abort_beat) begin
                    aborted = 1;
                    break;
                end
                chk({tag, "_addr"}, bus.err_addr, beats);
                chk({tag, "_data"}, bus.err_data, exp_err(sc[beats], beats, lbl));
                if (beats == stall_beat && stalled < stall_n) begin
                    bus.err_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.err_ready = 1'b1;
                    beats++;
                end
            end else begin
                bus.err_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted) begin
            chk({tag, "_done_seen"}, seen_done, 1);
            chk({tag, "_beats"}, beats, N);
            chk({tag, "_valid_at_done"}, bus.err_valid, 0);
            bus.err_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_idle"}, busy, 0);
            chk({tag, "_pred_held"}, pred_valid, 1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pvalid"}, pred_valid, 0);
        chk({tag, "_pclass"}, pred_class, 0);
        chk({tag, "_pscore"}, pred_score, 0);
        chk({tag, "_addr_err"}, addr_err, 0);
        chk({tag, "_evalid"}, bus.err_valid, 0);
        chk({tag, "_eaddr"}, bus.err_addr, 0);
        chk({tag, "_edata"}, bus.err_data, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_done = 1'b0; bus.in_addr = '0; bus.in_data = '0;
        bus.err_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;

        // 1: ascending scores, label 9
        for (int i = 0; i < N; i++) sc[i] = DW'(i * 256);
        start(9);
        chk("t1_busy", busy, 1);
        send_all();
        wait_err("t1");
        chk("t1_pvalid", pred_valid, 1);
        chk("t1_pclass", pred_class, 9);
        chk("t1_pscore", pred_score, 16'h0900);
        chk("t1_addr_err", addr_err, 0);
        drain("t1", -1, 0, -1);

        // 2: tie at classes 2 and 7
        for (int i = 0; i < N; i++) sc[i] = 16'hFF00;
        sc[2] = 16'h0300; sc[7] = 16'h0300;
        start(7);
        send_all();
        wait_err("t2");
        chk("t2_pclass", pred_class, 2);
        chk("t2_pscore", pred_score, 16'h0300);
        drain("t2", -1, 0, -1);

        // 3: 5-cycle stall on beat 4
        for (int i = 0; i < N; i++) sc[i] = DW'(i * 256);
        start(3);
        send_all();
        wait_err("t3");
        drain("t3", 4, 5, -1);

        // 4: saturation at the negative rail
        for (int i = 0; i < N; i++) sc[i] = 16'h0010;
        sc[0] = 16'h8000;
        start(0);
        send_all();
        wait_err("t4");
        chk("t4_pclass", pred_class, 1);
        chk("t4_pscore", pred_score, 16'h0010);
        chk("t4_err0_addr", bus.err_addr, 0);
        chk("t4_err0_sat", bus.err_data, 16'h8000);
        drain("t4", -1, 0, -1);

        // 5: class 5 never written, addr 9 held for 20 cycles
        for (int i = 0; i < N; i++) sc[i] = DW'(i * 256);
        sc[5] = 16'h0000;
        start(2);
        for (int i = 0; i < N - 1; i++) begin
            if (i != 5) begin
                @(negedge clk);
                bus.in_valid = 1'b1; bus.in_addr = AW'(i); bus.in_data = sc[i];
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_addr = 4'd9; bus.in_data = sc[9];
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_done = 1'b1;
        wait_err("t5");
        chk("t5_addr_err", addr_err, 1);
        chk("t5_pclass", pred_class, 9);
        drain("t5", -1, 0, -1);

        // 6: out-of-range label means no target
        for (int i = 0; i < N; i++) sc[i] = 16'h0100;
        start(12);
        chk("t6_addr_err", addr_err, 1);
        send_all();
        wait_err("t6");
        chk("t6_pclass", pred_class, 0);
        chk("t6_pscore", pred_score, 16'h0100);
        drain("t6", -1, 0, -1);

        // 7: reset during beat 3 of the error stream
        for (int i = 0; i < N; i++) sc[i] = DW'(i * 256);
        start(9);
        chk("t7_addr_err_clr", addr_err, 0);
        send_all();
        wait_err("t7");
        drain("t7", -1, 0, 3);
        chk("t7_pre_addr", bus.err_addr, 3);
        reset = 1'b0;
        #1;
        chk_all_zero("t7_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t7_no_done", done, 0);
        end
        reset = 1'b1;
        bus.err_ready = 1'b0;

        // 8: clean restart after abort
        for (int i = 0; i < N; i++) sc[i] = DW'((N - 1 - i) * 256);
        start(4);
        send_all();
        wait_err("t8");
        chk("t8_pclass", pred_class, 0);
        chk("t8_pscore", pred_score, 16'h0900);
        drain("t8", 0, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
